// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and helpers for the LED decoder block:
//                display-mode encoding and a one-hot select decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Widest select the onehot() helper supports; callers truncate the result
    localparam int c_MAX_SEL_W = 8;
    localparam int c_MAX_NLED  = 2**c_MAX_SEL_W;

    // Display modes, numerically equal to the mode input encoding
    typedef enum logic [1:0] {
        LED_STATIC = 2'd0,
        LED_BLINK  = 2'd1,
        LED_CHASE  = 2'd2,
        LED_BOUNCE = 2'd3
    } led_mode_t;

    // Decode a select value to a one-hot vector (bit sel set, all others clear)
    function automatic logic [c_MAX_NLED-1:0] onehot(input logic [c_MAX_SEL_W-1:0] sel);
        logic [c_MAX_NLED-1:0] w_oh;
        w_oh      = '0;
        w_oh[sel] = 1'b1;
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_decode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_decode_ctrl_if
//  Description : Control/LED bundle between the switch/enable source
//                (master) and the LED decoder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_decode_ctrl_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 4
);
    localparam int c_NLED = 2**SEL_W;

    logic [2:0]        enable;  // 74x138-style G1/G2A/G2B gate code
    logic [SEL_W-1:0]  switch;  // LED select / chase start position
    logic [1:0]        mode;    // display mode
    logic [DIV_W-1:0]  div;     // step period minus one
    logic [c_NLED-1:0] led;     // registered LED drive
    logic [SEL_W-1:0]  pos;     // registered chase/bounce position

    modport master (
        output enable, switch, mode, div,
        input  led, pos
    );

    modport slave (
        input  enable, switch, mode, div,
        output led, pos
    );

endinterface
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_prescaler
//  Description : Programmable step prescaler. Counts enabled cycles and
//                pulses tick when the count reaches div (period div+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
    parameter int DIV_W = 4
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             en,
    input  wire             clr,
    input  wire [DIV_W-1:0] div,
    output logic            tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    // Exact-match compare: if div drops below the count, the counter simply
    // wraps through zero before the next hit.
    assign w_hit = (r_cnt == div);
    assign tick  = en && w_hit;

    // Count enabled cycles; restart on hit or on a mode-entry clear, hold when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (clr || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_decode_ctrl
//  Description : 2**SEL_W-output LED decoder with 74x138-style enable
//                gating, registered output and static/blink/chase/bounce
//                display modes paced by a programmable prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_decode_ctrl
    import led_pkg::*;
#(
    parameter int         SEL_W      = 3,
    parameter logic [2:0] EN_CODE    = 3'b100,
    parameter int         DIV_W      = 4,
    parameter bit         ACTIVE_LOW = 1'b1
) (
    input  wire               clk,
    input  wire               rst,
    led_decode_ctrl_if.slave  bus
);

    localparam int               c_NLED     = 2**SEL_W;
    localparam logic [SEL_W-1:0] c_POS_LAST = SEL_W'(c_NLED - 1);
    localparam logic [SEL_W-1:0] c_POS_PREV = SEL_W'(c_NLED - 2);
    localparam logic [SEL_W-1:0] c_POS_ONE  = SEL_W'(1);
    localparam logic [c_NLED-1:0] c_DARK    = {c_NLED{ACTIVE_LOW}};

    // Registered state
    led_mode_t         r_mode_q;
    logic [SEL_W-1:0]  r_pos;
    logic              r_dir_up;
    logic              r_phase;
    logic [c_NLED-1:0] r_led;

    // Next-state and decode terms
    logic              w_en;
    led_mode_t         w_mode;
    logic              w_entry;
    logic              w_tick;
    logic [SEL_W-1:0]  w_pos_nxt;
    logic              w_dir_up_nxt;
    logic              w_phase_nxt;
    logic [c_NLED-1:0] w_pattern;
    logic [c_NLED-1:0] w_sw_onehot;

    assign w_en    = (bus.enable == EN_CODE);
    assign w_mode  = led_mode_t'(bus.mode);
    // A mode change restarts the pattern and wins over any same-cycle tick
    assign w_entry = w_en && (w_mode != r_mode_q);

    assign w_sw_onehot = c_NLED'(onehot(c_MAX_SEL_W'(bus.switch)));

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .clr  (w_entry),
        .div  (bus.div),
        .tick (w_tick)
    );

    // Next pattern state and lit pattern for the current mode
    always_comb begin
        w_pos_nxt    = r_pos;
        w_dir_up_nxt = r_dir_up;
        w_phase_nxt  = r_phase;
        w_pattern    = w_sw_onehot;

        if (w_entry) begin
            w_pos_nxt    = bus.switch;
            w_dir_up_nxt = 1'b1;
            w_phase_nxt  = 1'b1;
        end else begin
            case (r_mode_q)
                LED_STATIC: begin
                    w_pattern = w_sw_onehot;
                end
                LED_BLINK: begin
                    if (w_tick) begin
                        w_phase_nxt = ~r_phase;
                    end
                    if (!w_phase_nxt) begin
                        w_pattern = '0;
                    end
                end
                LED_CHASE: begin
                    if (w_tick) begin
                        // SEL_W-bit arithmetic wraps NLED-1 back to 0
                        w_pos_nxt = r_pos + c_POS_ONE;
                    end
                    w_pattern = c_NLED'(onehot(c_MAX_SEL_W'(w_pos_nxt)));
                end
                LED_BOUNCE: begin
                    if (w_tick) begin
                        if (r_dir_up) begin
                            if (r_pos == c_POS_LAST) begin
                                w_dir_up_nxt = 1'b0;
                                w_pos_nxt    = c_POS_PREV;
                            end else begin
                                w_pos_nxt = r_pos + c_POS_ONE;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir_up_nxt = 1'b1;
                                w_pos_nxt    = c_POS_ONE;
                            end else begin
                                w_pos_nxt = r_pos - c_POS_ONE;
                            end
                        end
                    end
                    w_pattern = c_NLED'(onehot(c_MAX_SEL_W'(w_pos_nxt)));
                end
                default: begin
                    w_pattern = w_sw_onehot;
                end
            endcase
        end
    end

    // State and LED register: blank and freeze while the gate is closed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= LED_STATIC;
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_phase  <= 1'b1;
            r_led    <= c_DARK;
        end else if (!w_en) begin
            r_led <= c_DARK;
        end else begin
            r_mode_q <= w_mode;
            r_pos    <= w_pos_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_phase  <= w_phase_nxt;
            r_led    <= ACTIVE_LOW ? ~w_pattern : w_pattern;
        end
    end

    assign bus.led = r_led;
    assign bus.pos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_led_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_decode_ctrl
//  Description : Self-checking bench for led_decode_ctrl. Two instances:
//                A (SEL_W=3, active-low) and B (SEL_W=4, active-high),
//                checked every cycle against a behavioural model, plus
//                directed vectors with fixed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_decode_ctrl;

    localparam int c_DIV_W = 4;
    localparam int c_EN    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for each instance
    int a_en = 4, a_sw = 0, a_md = 0, a_dv = 0;
    int b_en = 4, b_sw = 0, b_md = 0, b_dv = 0;

    // Model state per instance: mode, prescaler count, ticks since entry, start position
    int m_mode [2];
    int m_cnt  [2];
    int m_ticks[2];
    int m_start[2];

    int t4_pos[10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int t2_led[6]  = '{'hFB, 'hFB, 'hFF, 'hFF, 'hFB, 'hFB};

    always #5 clk = ~clk;

    led_decode_ctrl_if #(.SEL_W(3), .DIV_W(c_DIV_W)) bus_a ();
    led_decode_ctrl_if #(.SEL_W(4), .DIV_W(c_DIV_W)) bus_b ();

    led_decode_ctrl #(.SEL_W(3), .EN_CODE(3'b100), .DIV_W(c_DIV_W), .ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    led_decode_ctrl #(.SEL_W(4), .EN_CODE(3'b100), .DIV_W(c_DIV_W), .ACTIVE_LOW(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = 0;
            m_cnt[k]   = 0;
            m_ticks[k] = 0;
            m_start[k] = 0;
        end
    endtask

    // Position from start and number of steps taken since entry
    function automatic int cur_pos(input int k, input int nled);
        int p, t;
        case (m_mode[k])
            2: return (m_start[k] + m_ticks[k]) % nled;
            3: begin
                // Triangle walk 0..nled-1..1 with period 2*(nled-1)
                p = 2 * (nled - 1);
                t = (m_start[k] + m_ticks[k]) % p;
                return (t < nled) ? t : (p - t);
            end
            default: return m_start[k];
        endcase
    endfunction

    task automatic model_step(input int k, input int selw, input bit al,
                              input int en_v, input int sw, input int md, input int dv,
                              output int e_led, output int e_pos);
        int nled, mask, pat;
        nled = 1 << selw;
        mask = (1 << nled) - 1;
        pat  = 0;
        if (en_v != c_EN) begin
            e_led = al ? mask : 0;
            e_pos = cur_pos(k, nled);
            return;
        end
        if (md != m_mode[k]) begin
            m_mode[k]  = md;
            m_cnt[k]   = 0;
            m_ticks[k] = 0;
            m_start[k] = sw;
            pat        = 1 << sw;
        end else begin
            if (m_cnt[k] == dv) begin
                m_cnt[k] = 0;
                m_ticks[k]++;
            end else begin
                m_cnt[k] = (m_cnt[k] + 1) % (1 << c_DIV_W);
            end
            case (md)
                0:       pat = 1 << sw;
                1:       pat = (m_ticks[k] % 2 == 0) ? (1 << sw) : 0;
                default: pat = 1 << cur_pos(k, nled);
            endcase
        end
        e_led = al ? (~pat & mask) : pat;
        e_pos = cur_pos(k, nled);
    endtask

    task automatic apply();
        bus_a.enable = 3'(a_en);
        bus_a.switch = 3'(a_sw);
        bus_a.mode   = 2'(a_md);
        bus_a.div    = 4'(a_dv);
        bus_b.enable = 3'(b_en);
        bus_b.switch = 4'(b_sw);
        bus_b.mode   = 2'(b_md);
        bus_b.div    = 4'(b_dv);
    endtask

    // One clock: advance the model on the edge, compare 1 time unit later
    task automatic cycle();
        int ea, pa, eb, pb;
        apply();
        @(posedge clk);
        model_step(0, 3, 1'b1, a_en, a_sw, a_md, a_dv, ea, pa);
        model_step(1, 4, 1'b0, b_en, b_sw, b_md, b_dv, eb, pb);
        #1;
        check("model_a_led", 32'(bus_a.led), 32'(ea));
        check("model_a_pos", 32'(bus_a.pos), 32'(pa));
        check("model_b_led", 32'(bus_b.led), 32'(eb));
        check("model_b_pos", 32'(bus_b.pos), 32'(pb));
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_a_led"}, 32'(bus_a.led), 32'h0000_00FF);
        check({tag, "_a_pos"}, 32'(bus_a.pos), 32'h0);
        check({tag, "_b_led"}, 32'(bus_b.led), 32'h0000_0000);
        check({tag, "_b_pos"}, 32'(bus_b.pos), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        apply();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_led", 32'(bus_a.led), 32'h0000_00FF);
        check("rst_a_pos", 32'(bus_a.pos), 32'h0);
        check("rst_b_led", 32'(bus_b.led), 32'h0000_0000);
        check("rst_b_pos", 32'(bus_b.pos), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // STATIC decode and enable-gate sweep
        a_en = 4; a_md = 0; a_sw = 5;
        cycle();
        check("static_sw5", 32'(bus_a.led), 32'h0000_00DF);
        for (int e = 0; e < 8; e++) begin
            a_en = e;
            cycle();
            check("enable_sweep", 32'(bus_a.led), (e == 4) ? 32'h0000_00DF : 32'h0000_00FF);
        end

        // BLINK, div=1: two cycles lit, two dark
        a_en = 4; a_md = 1; a_dv = 1; a_sw = 2;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("blink_seq", 32'(bus_a.led), 32'(t2_led[i]));
        end

        // CHASE on A from 6 and on B from 14, both wrapping
        a_md = 2; a_dv = 0; a_sw = 6;
        b_en = 4; b_md = 2; b_dv = 0; b_sw = 14;
        for (int i = 0; i < 4; i++) begin
            cycle();
            a_sw = 3;
            b_sw = 9;
            check("chase_a_pos", 32'(bus_a.pos), 32'((6 + i) % 8));
            check("chase_a_led", 32'(bus_a.led), 32'(~(1 << ((6 + i) % 8)) & 'hFF));
            check("chase_b_pos", 32'(bus_b.pos), 32'((14 + i) % 16));
            check("chase_b_led", 32'(bus_b.led), 32'(1 << ((14 + i) % 16)));
        end

        // BOUNCE from 6 with endpoint turnarounds
        a_md = 3; a_sw = 6;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bounce_pos", 32'(bus_a.pos), 32'(t4_pos[i]));
            if (i < 3) check("bounce_led", 32'(bus_a.led), 32'(~(1 << t4_pos[i]) & 'hFF));
        end

        // CHASE paused by the enable gate
        a_md = 2; a_sw = 3;
        cycle();
        check("pause_entry_pos", 32'(bus_a.pos), 32'h3);
        a_en = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("pause_led", 32'(bus_a.led), 32'h0000_00FF);
            check("pause_pos", 32'(bus_a.pos), 32'h3);
        end
        a_en = 4;
        cycle();
        check("resume_pos", 32'(bus_a.pos), 32'h4);
        check("resume_led", 32'(bus_a.led), 32'h0000_00EF);

        // Asynchronous reset mid-BOUNCE, then re-entry on the first enabled edge
        a_md = 3; a_sw = 2;
        b_md = 3; b_sw = 11;
        repeat (3) cycle();
        async_reset_check("async_rst");
        cycle();
        check("post_rst_pos", 32'(bus_a.pos), 32'h2);
        check("post_rst_led", 32'(bus_a.led), 32'h0000_00FB);

        // Randomised traffic on both instances
        for (int i = 0; i < 600; i++) begin
            a_en = ($urandom_range(0, 9) < 8) ? c_EN : int'($urandom_range(0, 7));
            b_en = ($urandom_range(0, 9) < 8) ? c_EN : int'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) a_md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) b_md = int'($urandom_range(0, 3));
            a_sw = int'($urandom_range(0, 7));
            b_sw = int'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0)
                a_dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0)
                b_dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            cycle();
            if (i == 300) async_reset_check("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
